// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable clock prescalers with glitch-free divisor reload.
// Optional CLK_DIV_BANK_PHASE_EN adds cfg_phase for fixed inter-channel skew on restart.
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(50_000_000 - 1),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_DIV_BANK_PHASE_EN
  input  logic [CNT_W-1:0]  cfg_phase,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] w_hit, w_pend, w_acc;
  assign cfg_ready = ~|(w_hit & w_pend);
  assign w_acc = {NUM_CH{cfg_valid}} & w_hit & ~w_pend;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt, r_div, r_pdiv, w_eff_div, w_load;
    logic r_pend, r_clk, r_tick;
    assign w_hit[c] = (cfg_ch == CH_W'(c));
    assign w_pend[c] = r_pend;
    assign clk_out[c] = r_clk;
    assign tick[c] = r_tick;
    assign w_eff_div = r_pend ? r_pdiv : r_div;
`ifdef CLK_DIV_BANK_PHASE_EN
    logic [CNT_W-1:0] r_phase;
    always_ff @(posedge clk_in or posedge reset)
      if (reset) r_phase <= '0;
      else if (w_acc[c]) r_phase <= cfg_phase;
    assign w_load = (r_phase < w_eff_div) ? r_phase : w_eff_div;
`else
    assign w_load = '0;
`endif
    // accept and reload are exclusive: accept needs !r_pend, reload needs r_pend
    always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
        r_cnt <= '0;
        r_div <= DEFAULT_DIV;
        r_pdiv <= '0;
        r_pend <= 1'b0;
        r_clk <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (sync_req || !ch_en[c]) begin
          r_cnt <= w_load;
          r_clk <= 1'b0;
          r_tick <= 1'b0;
          if (r_pend) begin
            r_div <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else if (r_cnt == r_div) begin
          r_cnt <= '0;
          r_clk <= ~r_clk;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_div <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
        if (w_acc[c]) begin
          r_pdiv <= cfg_div;
          r_pend <= 1'b1;
        end
      end
  end
endmodule
